// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter and access sequencer for a single-ported data memory.
module dmem_arbiter #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        resp0_valid,
  output logic [31:0] resp0_rdata,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        resp1_valid,
  output logic [31:0] resp1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_last, r_owner, r_write;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic        w_idle, w_acc, w_resp, w_g0, w_g1;
  assign w_idle = (r_state == IDLE) & ~reset;
  assign w_acc  = r_state == ACCESS;
  assign w_resp = r_state == RESP;
  // r_last==1 means port 1 was served last, so port 0 wins a tie
  assign w_g0 = w_idle & req0_valid & (~req1_valid | r_last);
  assign w_g1 = w_idle & req1_valid & (~req0_valid | ~r_last);
  assign req0_ready  = w_g0;
  assign req1_ready  = w_g1;
  assign mem_addr    = w_acc ? r_addr : '0;
  assign mem_din     = w_acc ? r_wdata : '0;
  assign mem_read    = w_acc & ~r_write;
  assign mem_write   = w_acc & r_write & (r_cnt == 4'd0);
  assign resp0_valid = w_resp & ~r_owner;
  assign resp1_valid = w_resp & r_owner;
  assign resp0_rdata = resp0_valid ? r_rdata : '0;
  assign resp1_rdata = resp1_valid ? r_rdata : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_g0 | w_g1) begin
          r_owner <= w_g1;
          r_last  <= w_g1;
          r_write <= w_g1 ? req1_write : req0_write;
          r_addr  <= w_g1 ? req1_addr : req0_addr;
          r_wdata <= w_g1 ? req1_wdata : req0_wdata;
          r_cnt   <= CNT_INIT;
          r_state <= ACCESS;
        end
        ACCESS: if (r_cnt == 4'd0) begin
          r_rdata <= r_write ? '0 : mem_dout;
          r_state <= RESP;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of two arbiter instances (LATENCY 1 and 3), each with its own memory model.
module tb_dmem_arbiter;
  logic clk, rst;
  logic [1:0] r0v, r0w, r1v, r1w, rdy0, rdy1, rv0, rv1, mrd, mwr;
  logic [31:0] r0a[2], r0d[2], r1a[2], r1d[2], rd0[2], rd1[2], maddr[2], mdin[2], mdout[2];
  int n_chk = 0, n_err = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gen
    logic [31:0] mem [64];
    initial for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
    always @(posedge clk) if (mwr[g]) mem[maddr[g][7:2]] <= mdin[g];
    assign mdout[g] = mem[maddr[g][7:2]];
    dmem_arbiter #(.LATENCY(g ? 3 : 1)) dut (
      .clk(clk), .reset(rst),
      .req0_valid(r0v[g]), .req0_write(r0w[g]), .req0_addr(r0a[g]), .req0_wdata(r0d[g]),
      .req0_ready(rdy0[g]), .resp0_valid(rv0[g]), .resp0_rdata(rd0[g]),
      .req1_valid(r1v[g]), .req1_write(r1w[g]), .req1_addr(r1a[g]), .req1_wdata(r1d[g]),
      .req1_ready(rdy1[g]), .resp1_valid(rv1[g]), .resp1_rdata(rd1[g]),
      .mem_addr(maddr[g]), .mem_din(mdin[g]), .mem_read(mrd[g]), .mem_write(mwr[g]),
      .mem_dout(mdout[g])
    );
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(int d, int p);
    return p ? rdy1[d] : rdy0[d];
  endfunction
  function automatic logic rv(int d, int p);
    return p ? rv1[d] : rv0[d];
  endfunction
  function automatic logic [31:0] rd(int d, int p);
    return p ? rd1[d] : rd0[d];
  endfunction
  function automatic logic any_out(int d);
    return |{rdy0[d], rdy1[d], rv0[d], rv1[d], mrd[d], mwr[d], maddr[d], mdin[d], rd0[d], rd1[d]};
  endfunction

  task automatic drive(int d, int p, logic v, logic w, logic [31:0] a, logic [31:0] wd);
    if (p == 0) begin r0v[d] = v; r0w[d] = w; r0a[d] = a; r0d[d] = wd; end
    else begin r1v[d] = v; r1w[d] = w; r1a[d] = a; r1d[d] = wd; end
  endtask

  task automatic xact(int d, int p, logic w, logic [31:0] a, logic [31:0] wd, logic [31:0] ex,
                      int lat, string tag);
    int n = 0;
    @(negedge clk);
    drive(d, p, 1'b1, w, a, wd);
    #1;
    while (!rdy(d, p) && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, ".ready"}, 32'(rdy(d, p)), 1);
    chk({tag, ".other_ready"}, 32'(rdy(d, 1 - p)), 0);
    @(negedge clk);
    drive(d, p, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 1; k <= lat; k++) begin
      chk({tag, ".rd_wr"}, {mrd[d], mwr[d]}, {~w, w && k == lat});
      chk({tag, ".addr"}, maddr[d], a);
      chk({tag, ".din"}, mdin[d], wd);
      chk({tag, ".no_resp"}, {rv0[d], rv1[d]}, 0);
      @(negedge clk);
    end
    chk({tag, ".resp"}, 32'(rv(d, p)), 1);
    chk({tag, ".other_resp"}, 32'(rv(d, 1 - p)), 0);
    chk({tag, ".rdata"}, rd(d, p), ex);
    chk({tag, ".mem_idle"}, {mrd[d], mwr[d]}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ng, nr, last_t, c;
    rst = 1;
    for (int d = 0; d < 2; d++) begin
      drive(d, 0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(d, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    r0v[0] = 1;
    repeat (2) @(negedge clk);
    chk("rst.outs0", 32'(any_out(0)), 0);
    chk("rst.outs1", 32'(any_out(1)), 0);
    r0v[0] = 0;
    rst = 0;

    xact(0, 0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1, "st0");
    xact(0, 1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1, "ld1");

    ng = 0; nr = 0; last_t = 0; c = 0;
    @(negedge clk);
    drive(0, 0, 1'b1, 1'b0, 32'h0, 32'h0);
    drive(0, 1, 1'b1, 1'b0, 32'h4, 32'h0);
    while ((ng < 4 || nr < 4) && c < 40) begin
      #1;
      chk("alt.both_ready", 32'(rdy0[0] & rdy1[0]), 0);
      if ((rdy0[0] | rdy1[0]) && ng < 4) begin
        chk("alt.order", 32'(rdy1[0]), 32'(ng % 2));
        if (ng > 0) chk("alt.gap", c - last_t, 3);
        last_t = c;
        ng++;
      end
      if (rv0[0]) begin chk("alt.rd0", rd0[0], 32'hA000_0000); nr++; end
      if (rv1[0]) begin chk("alt.rd1", rd1[0], 32'hA000_0001); nr++; end
      @(negedge clk);
      c++;
      if (ng == 4) begin
        drive(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    chk("alt.grants", ng, 4);
    chk("alt.resps", nr, 4);

    xact(1, 1, 1'b0, 32'h8, 32'h0, 32'hA000_0002, 3, "l3ld");
    xact(1, 0, 1'b1, 32'hC, 32'h12345678, 32'h0, 3, "l3st");
    xact(1, 1, 1'b0, 32'hC, 32'h0, 32'h12345678, 3, "l3rb");

    @(negedge clk);
    drive(1, 0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
    #1;
    chk("rmid.ready", 32'(rdy0[1]), 1);
    @(negedge clk);
    drive(1, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rmid.c1", {mrd[1], mwr[1]}, 0);
    chk("rmid.addr", maddr[1], 32'h20);
    @(negedge clk);
    chk("rmid.c2", {mrd[1], mwr[1]}, 0);
    rst = 1;
    #1;
    chk("rmid.outs", 32'(any_out(1)), 0);
    @(negedge clk);
    rst = 0;
    repeat (5) begin
      @(negedge clk);
      chk("rmid.no_resp", {rv0[1], rv1[1], mwr[1]}, 0);
    end
    xact(1, 0, 1'b0, 32'h20, 32'h0, 32'hA000_0008, 3, "rmid.rb");

    repeat (10) begin
      @(negedge clk);
      chk("idle0", 32'(any_out(0)), 0);
      chk("idle1", 32'(any_out(1)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
